// File: rtl/pong_pkg.sv
// Shared constants, colours and state type for the Pong pixel generator.
package pong_pkg;

    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] V_VIS    = 10'd480;

    localparam logic [9:0] WALL_X_L = 10'd32;
    localparam logic [9:0] WALL_X_R = 10'd35;

    localparam logic [9:0] PAD_X_L  = 10'd600;
    localparam logic [9:0] PAD_X_R  = 10'd603;
    localparam logic [9:0] PAD_LAST = 10'd71;
    localparam logic [9:0] PAD_Y0   = 10'd204;

    localparam logic [9:0] BALL_LAST = 10'd7;
    localparam logic [9:0] BALL_X0   = 10'd316;
    localparam logic [9:0] BALL_Y0   = 10'd236;

    localparam logic [9:0] TICK_X = 10'd0;
    localparam logic [9:0] TICK_Y = 10'd481;

    localparam logic [11:0] COL_WALL = 12'h00F;
    localparam logic [11:0] COL_PAD  = 12'h0F0;
    localparam logic [11:0] COL_BALL = 12'hF00;
    localparam logic [11:0] COL_BG   = 12'h000;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2
    } state_t;

    function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pong_graph_if.sv
// Pixel-position, button and colour/event signals between the sync stage and pong_graph.
interface pong_graph_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        btn_up;
    logic        btn_down;
    logic [11:0] rgb;
    logic        hit;
    logic        miss;

    modport master (
        output pixel_x, pixel_y, video_on, btn_up, btn_down,
        input  rgb, hit, miss
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, btn_up, btn_down,
        output rgb, hit, miss
    );
endinterface

// File: rtl/pong_paddle.sv
// Player paddle: position register stepped once per frame, clamped to the screen, plus draw test.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int PAD_V = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refr_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic [9:0] pad_y,
    output logic       pad_on
);
    localparam logic [9:0] PAD_V_W = 10'(PAD_V);

    logic [9:0] pad_y_r;

    // Paddle top moves a whole step or not at all; opposing buttons cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_y_r <= PAD_Y0;
        end else if (refr_tick) begin
            if (btn_down && !btn_up && (pad_y_r + PAD_LAST < V_VIS - 10'd1 - PAD_V_W)) begin
                pad_y_r <= pad_y_r + PAD_V_W;
            end else if (btn_up && !btn_down && (pad_y_r > PAD_V_W)) begin
                pad_y_r <= pad_y_r - PAD_V_W;
            end else begin
                pad_y_r <= pad_y_r;
            end
        end else begin
            pad_y_r <= pad_y_r;
        end
    end

    assign pad_y  = pad_y_r;
    assign pad_on = in_range(pixel_x, PAD_X_L, PAD_X_R) &&
                    in_range(pixel_y, pad_y_r, pad_y_r + PAD_LAST);

endmodule

// File: rtl/pong_graph.sv
// Pong pixel generator: wall, paddle and ball state, serve/play/miss control and colour output.
module pong_graph
    import pong_pkg::*;
#(
    parameter int BALL_V       = 2,
    parameter int PAD_V        = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       rst,
    pong_graph_if.slave bus
);
    localparam logic [9:0] BV         = 10'(BALL_V);
    localparam logic [9:0] BV_NEG     = 10'd0 - BV;
    localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);
    localparam logic [5:0] MISS_LAST  = 6'(MISS_FRAMES - 1);

    logic        tick_prev_r;
    logic        tick_cond_s;
    logic        refr_tick_s;
    state_t      state_r;
    logic [5:0]  frame_cnt_r;
    logic [9:0]  ball_x_r, ball_y_r;
    logic [9:0]  x_delta_r, y_delta_r;
    logic        hit_r, miss_r;
    logic [11:0] rgb_r;

    logic [9:0]  pad_y_s;
    logic        pad_on_s, wall_on_s, ball_on_s;
    logic [9:0]  x_delta_s, y_delta_s;
    logic        pad_hit_s, edge_miss_s;
    logic [11:0] rgb_s;

    // Pixel counts dwell several clocks, so the frame tick is the rising edge of the match.
    assign tick_cond_s = (bus.pixel_y == TICK_Y) && (bus.pixel_x == TICK_X);
    assign refr_tick_s = tick_cond_s && !tick_prev_r;

    pong_paddle #(.PAD_V(PAD_V)) u_paddle (
        .clk       (clk),
        .rst       (rst),
        .refr_tick (refr_tick_s),
        .btn_up    (bus.btn_up),
        .btn_down  (bus.btn_down),
        .pixel_x   (bus.pixel_x),
        .pixel_y   (bus.pixel_y),
        .pad_y     (pad_y_s),
        .pad_on    (pad_on_s)
    );

    // Collision decisions on the current ball position; a paddle return overrides an edge miss.
    always_comb begin
        y_delta_s   = y_delta_r;
        x_delta_s   = x_delta_r;
        pad_hit_s   = 1'b0;
        edge_miss_s = 1'b0;
        if (ball_y_r <= BV) begin
            y_delta_s = BV;
        end else if (ball_y_r + BALL_LAST >= V_VIS - 10'd1 - BV) begin
            y_delta_s = BV_NEG;
        end else begin
            y_delta_s = y_delta_r;
        end
        pad_hit_s = in_range(ball_x_r + BALL_LAST, PAD_X_L, PAD_X_R) &&
                    !x_delta_r[9] && (x_delta_r != 10'd0) &&
                    (ball_y_r <= pad_y_s + PAD_LAST) &&
                    (ball_y_r + BALL_LAST >= pad_y_s);
        edge_miss_s = !pad_hit_s && (ball_x_r + BALL_LAST >= H_VIS - 10'd1);
        if (pad_hit_s) begin
            x_delta_s = BV_NEG;
        end else if (ball_x_r <= WALL_X_R + BV) begin
            x_delta_s = BV;
        end else begin
            x_delta_s = x_delta_r;
        end
    end

    // Ball state machine, stepped once per frame; hit/miss are one-clock registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= SERVE;
            frame_cnt_r <= 6'd0;
            ball_x_r    <= BALL_X0;
            ball_y_r    <= BALL_Y0;
            x_delta_r   <= BV_NEG;
            y_delta_r   <= BV;
            hit_r       <= 1'b0;
            miss_r      <= 1'b0;
        end else begin
            hit_r  <= 1'b0;
            miss_r <= 1'b0;
            if (refr_tick_s) begin
                case (state_r)
                    SERVE: begin
                        ball_x_r <= BALL_X0;
                        ball_y_r <= BALL_Y0;
                        if (frame_cnt_r == SERVE_LAST) begin
                            state_r     <= PLAY;
                            frame_cnt_r <= 6'd0;
                            x_delta_r   <= BV_NEG;
                            y_delta_r   <= BV;
                        end else begin
                            frame_cnt_r <= frame_cnt_r + 6'd1;
                        end
                    end
                    PLAY: begin
                        x_delta_r <= x_delta_s;
                        y_delta_r <= y_delta_s;
                        ball_x_r  <= ball_x_r + x_delta_s;
                        ball_y_r  <= ball_y_r + y_delta_s;
                        hit_r     <= pad_hit_s;
                        if (edge_miss_s) begin
                            miss_r      <= 1'b1;
                            state_r     <= MISS;
                            frame_cnt_r <= 6'd0;
                        end
                    end
                    MISS: begin
                        if (frame_cnt_r == MISS_LAST) begin
                            state_r     <= SERVE;
                            frame_cnt_r <= 6'd0;
                            ball_x_r    <= BALL_X0;
                            ball_y_r    <= BALL_Y0;
                        end else begin
                            frame_cnt_r <= frame_cnt_r + 6'd1;
                        end
                    end
                    default: begin
                        state_r     <= SERVE;
                        frame_cnt_r <= 6'd0;
                    end
                endcase
            end
        end
    end

    assign wall_on_s = in_range(bus.pixel_x, WALL_X_L, WALL_X_R);
    assign ball_on_s = (state_r != MISS) &&
                       in_range(bus.pixel_x, ball_x_r, ball_x_r + BALL_LAST) &&
                       in_range(bus.pixel_y, ball_y_r, ball_y_r + BALL_LAST);

    // Colour priority: wall over paddle over ball over background, blanked outside video.
    always_comb begin
        rgb_s = COL_BG;
        if (!bus.video_on) begin
            rgb_s = COL_BG;
        end else if (wall_on_s) begin
            rgb_s = COL_WALL;
        end else if (pad_on_s) begin
            rgb_s = COL_PAD;
        end else if (ball_on_s) begin
            rgb_s = COL_BALL;
        end else begin
            rgb_s = COL_BG;
        end
    end

    // Output colour register and tick edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_r       <= COL_BG;
            tick_prev_r <= 1'b0;
        end else begin
            rgb_r       <= rgb_s;
            tick_prev_r <= tick_cond_s;
        end
    end

    assign bus.rgb  = rgb_r;
    assign bus.hit  = hit_r;
    assign bus.miss = miss_r;

endmodule

// File: tb/tb_pong_graph.sv
// Scoreboard bench for pong_graph: directed frame ticks and pixel probes with hand-derived colours/events.
module tb_pong_graph;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pong_graph_if bus ();

    pong_graph dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors   = 0;
    int checks   = 0;
    int tick_num = 0;

    logic [11:0] rgb_q[$];
    string       name_q[$];
    int          hit_q[$];
    int          miss_q[$];

    logic probe_req = 1'b0;
    logic probe_ack = 1'b0;

    // rgb has one clock of latency, so a probe's result is valid one clock after it is driven
    always @(posedge clk) probe_ack <= probe_req;

    always @(negedge clk) begin
        if (probe_ack) begin
            checks++;
            if (rgb_q.size() == 0) begin
                errors++;
                $display("FAIL rgb_unexpected: got %h, nothing queued", bus.rgb);
            end else begin
                logic [11:0] exp;
                string nm;
                exp = rgb_q.pop_front();
                nm  = name_q.pop_front();
                if (bus.rgb !== exp) begin
                    errors++;
                    $display("FAIL %s: rgb got %h want %h", nm, bus.rgb, exp);
                end
            end
        end
        if (!rst && bus.hit !== 1'b0) begin
            checks++;
            if (hit_q.size() == 0) begin
                errors++;
                $display("FAIL hit_unexpected: hit=%b at tick %0d, none expected", bus.hit, tick_num);
            end else begin
                int e;
                e = hit_q.pop_front();
                if (e != tick_num) begin
                    errors++;
                    $display("FAIL hit_tick: got tick %0d want %0d", tick_num, e);
                end
            end
        end
        if (!rst && bus.miss !== 1'b0) begin
            checks++;
            if (miss_q.size() == 0) begin
                errors++;
                $display("FAIL miss_unexpected: miss=%b at tick %0d, none expected", bus.miss, tick_num);
            end else begin
                int e;
                e = miss_q.pop_front();
                if (e != tick_num) begin
                    errors++;
                    $display("FAIL miss_tick: got tick %0d want %0d", tick_num, e);
                end
            end
        end
    end

    task automatic check_now(input string nm, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic probe(input string nm, input int x, input int y, input logic vo,
                         input logic [11:0] exp);
        @(posedge clk); #1;
        bus.pixel_x  = 10'(x);
        bus.pixel_y  = 10'(y);
        bus.video_on = vo;
        rgb_q.push_back(exp);
        name_q.push_back(nm);
        probe_req = 1'b1;
        @(posedge clk); #1;
        probe_req = 1'b0;
    endtask

    // Hold the frame-tick pixel for the full 4-clock dwell; only the first clock may tick.
    task automatic do_tick(input logic up, input logic dn);
        @(posedge clk); #1;
        bus.btn_up   = up;
        bus.btn_down = dn;
        bus.pixel_x  = 10'd0;
        bus.pixel_y  = 10'd481;
        bus.video_on = 1'b0;
        tick_num++;
        repeat (4) @(posedge clk);
        #1;
        bus.pixel_x  = 10'd1;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
    endtask

    task automatic run_ticks(input int n, input logic up, input logic dn);
        for (int i = 0; i < n; i++) do_tick(up, dn);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pixel_x  = 10'd1;
        bus.pixel_y  = 10'd0;
        bus.video_on = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_rgb",  bus.rgb, 12'h000);
        check_now("reset_hit",  {11'd0, bus.hit}, 12'h000);
        check_now("reset_miss", {11'd0, bus.miss}, 12'h000);
        @(negedge clk);
        rst = 1'b0;

        // Reset picture
        probe("pad_top",      601, 204, 1'b1, 12'h0F0);
        probe("pad_bottom",   601, 275, 1'b1, 12'h0F0);
        probe("below_pad",    601, 276, 1'b1, 12'h000);
        probe("left_of_pad",  599, 210, 1'b1, 12'h000);
        probe("wall",          33, 100, 1'b1, 12'h00F);
        probe("wall_edge",     35, 479, 1'b1, 12'h00F);
        probe("ball",         317, 237, 1'b1, 12'hF00);
        probe("ball_corner",  323, 243, 1'b1, 12'hF00);
        probe("right_of_ball",324, 243, 1'b1, 12'h000);
        probe("background",   700, 100, 1'b1, 12'h000);
        probe("video_off",    601, 204, 1'b0, 12'h000);

        // Run A: paddle limits, bounces and a paddle return
        do_tick(1'b0, 1'b0);
        probe("pad_idle", 601, 204, 1'b1, 12'h0F0);
        do_tick(1'b1, 1'b1);
        probe("pad_both", 601, 204, 1'b1, 12'h0F0);
        do_tick(1'b0, 1'b1);
        probe("pad_step_gap", 601, 207, 1'b1, 12'h000);
        probe("pad_step_top", 601, 208, 1'b1, 12'h0F0);
        run_ticks(57, 1'b0, 1'b1);
        probe("pad_lim_top",   601, 404, 1'b1, 12'h0F0);
        probe("pad_lim_above", 601, 403, 1'b1, 12'h000);
        probe("pad_lim_bot",   601, 475, 1'b1, 12'h0F0);
        probe("pad_lim_below", 601, 476, 1'b1, 12'h000);
        probe("serve_held",    316, 236, 1'b1, 12'hF00);
        do_tick(1'b1, 1'b1);
        probe("play1_ball",    314, 238, 1'b1, 12'hF00);
        probe("play1_left",    313, 238, 1'b1, 12'h000);
        probe("play1_corner",  321, 245, 1'b1, 12'hF00);
        probe("play1_beyond",  322, 245, 1'b1, 12'h000);
        probe("pad_both_lim",  601, 404, 1'b1, 12'h0F0);
        run_ticks(70, 1'b1, 1'b0);
        probe("pad_up_top",    601, 124, 1'b1, 12'h0F0);
        probe("pad_up_above",  601, 123, 1'b1, 12'h000);
        probe("pad_up_bot",    601, 195, 1'b1, 12'h0F0);
        probe("pad_up_below",  601, 196, 1'b1, 12'h000);
        run_ticks(46, 1'b0, 1'b0);
        probe("bottom_ball",   82, 477, 1'b1, 12'hF00);
        probe("bottom_below",  82, 478, 1'b1, 12'h000);
        do_tick(1'b0, 1'b0);
        probe("bounce_up",     80, 468, 1'b1, 12'hF00);
        probe("bounce_up_bot", 80, 475, 1'b1, 12'h000 | 12'hF00);
        probe("bounce_up_out", 80, 476, 1'b1, 12'h000);
        run_ticks(22, 1'b0, 1'b0);
        probe("at_wall_ball",  36, 424, 1'b1, 12'hF00);
        probe("at_wall_wall",  35, 424, 1'b1, 12'h00F);
        do_tick(1'b0, 1'b0);
        probe("wall_bounce",   38, 422, 1'b1, 12'hF00);
        probe("wall_gap",      37, 422, 1'b1, 12'h000);
        run_ticks(210, 1'b0, 1'b0);
        probe("top_ball",     458, 2, 1'b1, 12'hF00);
        probe("top_above",    458, 1, 1'b1, 12'h000);
        do_tick(1'b0, 1'b0);
        probe("top_bounce",   460, 4, 1'b1, 12'hF00);
        probe("top_gap",      460, 3, 1'b1, 12'h000);
        run_ticks(67, 1'b0, 1'b0);
        probe("near_pad_ball", 594, 138, 1'b1, 12'hF00);
        probe("near_pad_pad",  601, 138, 1'b1, 12'h0F0);
        probe("near_pad_left", 593, 138, 1'b1, 12'h000);
        hit_q.push_back(480);
        do_tick(1'b0, 1'b0);
        probe("hit_ball",      592, 140, 1'b1, 12'hF00);
        probe("hit_ball_r",    599, 140, 1'b1, 12'hF00);
        probe("hit_pad",       600, 140, 1'b1, 12'h0F0);
        do_tick(1'b0, 1'b0);
        probe("return_ball",   590, 142, 1'b1, 12'hF00);
        probe("return_gap",    598, 142, 1'b1, 12'h000);
        probe("return_corner", 597, 149, 1'b1, 12'hF00);

        // Mid-PLAY asynchronous reset
        probe("pre_reset_ball", 591, 143, 1'b1, 12'hF00);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_now("async_reset_rgb", bus.rgb, 12'h000);
        check_now("async_reset_hit", {11'd0, bus.hit}, 12'h000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick_num = 0;
        probe("rst_pad_top",   601, 204, 1'b1, 12'h0F0);
        probe("rst_pad_above", 601, 203, 1'b1, 12'h000);
        probe("rst_ball",      316, 236, 1'b1, 12'hF00);

        // Run B: paddle left in place, the ball escapes
        run_ticks(60, 1'b0, 1'b0);
        probe("b_serve_held", 316, 236, 1'b1, 12'hF00);
        do_tick(1'b0, 1'b0);
        probe("b_play1",      314, 238, 1'b1, 12'hF00);
        run_ticks(437, 1'b0, 1'b0);
        probe("edge_ball",    632, 176, 1'b1, 12'hF00);
        probe("edge_corner",  639, 183, 1'b1, 12'hF00);
        probe("edge_left",    631, 176, 1'b1, 12'h000);
        miss_q.push_back(499);
        do_tick(1'b0, 1'b0);
        probe("miss_hidden",  633, 177, 1'b1, 12'h000);
        run_ticks(29, 1'b0, 1'b0);
        probe("miss_still_hidden", 316, 236, 1'b1, 12'h000);
        do_tick(1'b0, 1'b0);
        probe("recentred",    316, 236, 1'b1, 12'hF00);
        probe("recentred_l",  315, 236, 1'b1, 12'h000);
        do_tick(1'b0, 1'b0);
        probe("serve_again",  316, 236, 1'b1, 12'hF00);
        probe("serve_vo_off", 316, 236, 1'b0, 12'h000);

        repeat (3) @(posedge clk);
        #1;
        check_now("rgb_queue_drained",  12'(rgb_q.size()),  12'h000);
        check_now("hit_queue_drained",  12'(hit_q.size()),  12'h000);
        check_now("miss_queue_drained", 12'(miss_q.size()), 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_graph.md
Name: pong_graph

Overview:
Pixel generator for Pong; sits directly upstream of the VGA sync/output stage and supplies its 12-bit RGB.
Consumes the sync stage's pixel_x, pixel_y and video_on, and produces the colour of the current pixel.
Holds all game-object state: wall, player paddle and ball.
Positions update once per frame on an internally generated refresh tick; a play/serve/miss state machine controls the ball.

Parameters:
BALL_V, 2, ball speed per frame in x and y (pixels)
PAD_V, 4, paddle speed per frame (pixels)
SERVE_FRAMES, 60, frames the ball sits centred before launch
MISS_FRAMES, 30, frames the ball stays hidden after a miss

Ports:
clk  in  1  100 MHz system clock
rst  in  1  asynchronous, active-high reset
pixel_x  in  10  current horizontal count, 0-799
pixel_y  in  10  current vertical count, 0-524
video_on  in  1  high in the visible 640x480 region
btn_up  in  1  paddle up, already debounced, level
btn_down  in  1  paddle down, already debounced, level
rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
hit  out  1  one-clk pulse when the ball is returned by the paddle
miss  out  1  one-clk pulse when the ball leaves the right edge

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values:
  - rgb=0, hit=0, miss=0, state=SERVE, frame counter=0.
  - pad_y=204 (paddle top); ball_x=316, ball_y=236 (ball top-left).
  - x_delta=-BALL_V, y_delta=+BALL_V.
- Geometry:
  - Wall occupies x 32..35, full height.
  - Paddle occupies x 600..603, y pad_y..pad_y+71.
  - Ball is an 8x8 square, ball_x..ball_x+7 by ball_y..ball_y+7.
- refr_tick: a single-clk pulse on the rising edge of (pixel_y==481 && pixel_x==0). Pixel counts hold for 4 clk, so the previous value is registered and edge-detected. Exactly one tick per frame.
- Paddle update, on refr_tick only:
  - btn_down && pad_y+71 < 479-PAD_V: pad_y += PAD_V.
  - btn_up && pad_y > PAD_V: pad_y -= PAD_V.
  - Both buttons pressed, or the limit reached: pad_y holds. The paddle never partially steps.
- State machine, advancing on refr_tick only:
  - SERVE: ball held at 316,236. Frame counter counts to SERVE_FRAMES-1, then goes to PLAY with counter cleared and x_delta=-BALL_V, y_delta=+BALL_V.
  - PLAY: collisions are evaluated on the current position. The new deltas are chosen first, then the position is updated by the new deltas in the same tick.
    - Top, ball_y <= BALL_V: y_delta=+BALL_V.
    - Bottom, ball_y+7 >= 479-BALL_V: y_delta=-BALL_V.
    - Wall, ball_x <= 35+BALL_V: x_delta=+BALL_V.
    - Paddle: ball_x+7 in 600..603, x_delta>0, and ball y-range overlaps paddle y-range. Result: x_delta=-BALL_V and hit pulses.
    - Miss: ball_x+7 >= 639. Result: miss pulses, go to MISS, counter cleared.
    - Corner case: vertical and horizontal rules apply independently in the same tick.
    - Paddle hit and miss in the same tick: hit wins, no miss.
  - MISS: ball not drawn. Counter counts to MISS_FRAMES-1, then goes to SERVE with the ball recentred.
- Arithmetic:
  - Positions are 10-bit unsigned; deltas are 10-bit two's complement, added modulo 1024.
  - The rules above guarantee no wrap in PLAY.
  - Frame counter is 6 bits wide, sized to hold max(SERVE_FRAMES, MISS_FRAMES).
- hit and miss are registered. They are high for exactly the one clk following the refr_tick that caused them.
- Colour, with priority wall > paddle > ball > background:
  - Wall 12'h00F, paddle 12'h0F0, ball 12'hF00 (not drawn in MISS), background 12'h000.
  - video_on=0 forces 0.
- rgb is registered with 1 clk latency from pixel_x/pixel_y/video_on. This is well inside the 4-clk pixel period.
- Reset asserted mid-frame returns every register to its reset value immediately; operation resumes from SERVE on the next refr_tick after release.

Decomposition:
- Shared package pong_pkg: screen constants (H_VIS=640, V_VIS=480), wall/paddle/ball geometry, colour constants, state typedef {SERVE, PLAY, MISS}.
- One sub-module, pong_paddle: paddle register, clamping and draw-region compare; inputs refr_tick and the buttons.

Test Plan:
- Reset, then run 1 frame with no buttons -> rgb=12'h0F0 at (601,204), 12'h00F at (33,100), 12'hF00 at (317,237), 0 at (700,100) and whenever video_on=0; exactly one refr_tick per 800x525 pixel frame.
- Hold btn_down for 100 frames -> pad_y steps +4 per frame and stops at 404 (bottom 475); hold both buttons -> pad_y unchanged.
- After 60 frames in SERVE -> first PLAY tick moves the ball to (314,238); ball reaches the wall at x<=37 -> x_delta becomes +2 on that tick.
- Ball at y=1 moving up -> next tick y=3, y_delta=+2; ball at bottom 477 -> reverses to -2.
- Paddle positioned to overlap and the ball approaching -> hit pulses once (1 clk), x_delta=-2, miss stays 0.
- Paddle moved away -> miss pulses once; ball not drawn for 30 frames; ball then recentred at (316,236) in SERVE; reset asserted mid-PLAY restores all reset values asynchronously.
